// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter onto a single valid/ready memory port.
// The grant is held for the whole access; a watchdog force-completes hung accesses with an error flag.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic [31:0]       s_rdata
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state, state_nxt;
  logic             last_grant;
  logic [CNT_W-1:0] count;
  logic             enter;
  logic             timeout;
  logic             done;

  // s_valid depends only on registered state, never on s_ready
  assign s_valid  = (state != IDLE);
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    timeout   = (TIMEOUT > 0) && (count == CNT_LAST) && !s_ready;
    done      = 1'b0;
    m0_ready  = 1'b0;
    m0_err    = 1'b0;
    m1_ready  = 1'b0;
    m1_err    = 1'b0;
    s_addr    = (state == GRANT1) ? m1_addr  : m0_addr;
    s_wdata   = (state == GRANT1) ? m1_wdata : m0_wdata;
    s_wstrb   = (state == GRANT1) ? m1_wstrb : m0_wstrb;
    case (state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_nxt = last_grant ? GRANT0 : GRANT1;
          enter     = 1'b1;
        end else if (m0_valid) begin
          state_nxt = GRANT0;
          enter     = 1'b1;
        end else if (m1_valid) begin
          state_nxt = GRANT1;
          enter     = 1'b1;
        end
      end
      GRANT0: begin
        done     = m0_valid && (s_ready || timeout);
        m0_ready = done;
        m0_err   = m0_valid && timeout;
        if (!m0_valid) begin
          state_nxt = IDLE;
        end else if (done) begin
          state_nxt = m1_valid ? GRANT1 : IDLE;
          enter     = m1_valid;
        end
      end
      GRANT1: begin
        done     = m1_valid && (s_ready || timeout);
        m1_ready = done;
        m1_err   = m1_valid && timeout;
        if (!m1_valid) begin
          state_nxt = IDLE;
        end else if (done) begin
          state_nxt = m0_valid ? GRANT0 : IDLE;
          enter     = m0_valid;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Entering a grant records the winner and restarts the watchdog; the counter saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      count      <= '0;
    end else begin
      state <= state_nxt;
      if (enter) begin
        last_grant <= (state_nxt == GRANT1);
        count      <= '0;
      end else if (state != IDLE && count != '1) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mv [2];
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  ms [2];
  logic        m0_ready, m1_ready, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: current owner (-1 = none), last winner, cycles waited in current grant
  int   owner = -1, last = 1, waited = 0;
  int   n_owner, n_last, n_waited;
  logic e_rdy [2];
  logic e_err [2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(mv[0]), .m0_ready(m0_ready), .m0_addr(ma[0]), .m0_wdata(mw[0]),
    .m0_wstrb(ms[0]), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(mv[1]), .m1_ready(m1_ready), .m1_addr(ma[1]), .m1_wdata(mw[1]),
    .m1_wstrb(ms[1]), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Settle after input changes, compare against the model, and compute the model's next state
  task automatic eval();
    logic        v   [2];
    logic        rdy [2];
    logic        err [2];
    logic [31:0] rd  [2];
    logic        done;
    #1;
    v[0] = mv[0];       v[1] = mv[1];
    rdy[0] = m0_ready;  rdy[1] = m1_ready;
    err[0] = m0_err;    err[1] = m1_err;
    rd[0] = m0_rdata;   rd[1] = m1_rdata;
    done = 1'b0;
    e_rdy[0] = 1'b0; e_rdy[1] = 1'b0;
    e_err[0] = 1'b0; e_err[1] = 1'b0;
    chk("s_valid", 32'(s_valid), 32'(owner >= 0));
    if (owner >= 0) begin
      chk("s_addr", s_addr, ma[owner]);
      chk("s_wdata", s_wdata, mw[owner]);
      chk("s_wstrb", 32'(s_wstrb), 32'(ms[owner]));
      if (v[owner]) begin
        done = s_ready || (waited == TO - 1);
        e_rdy[owner] = done;
        e_err[owner] = done && !s_ready;
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_ready", i), 32'(rdy[i]), 32'(e_rdy[i]));
      chk($sformatf("m%0d_err", i), 32'(err[i]), 32'(e_err[i]));
      if (e_rdy[i] && !e_err[i]) chk($sformatf("m%0d_rdata", i), rd[i], s_rdata);
    end
    n_owner = owner; n_last = last; n_waited = waited;
    if (owner < 0) begin
      if (v[0] && v[1]) n_owner = 1 - last;
      else if (v[0])    n_owner = 0;
      else if (v[1])    n_owner = 1;
      if (n_owner >= 0) begin n_last = n_owner; n_waited = 0; end
    end else if (!v[owner]) begin
      n_owner = -1;
    end else if (done) begin
      if (v[1 - owner]) begin n_owner = 1 - owner; n_last = n_owner; n_waited = 0; end
      else n_owner = -1;
    end else begin
      n_waited = waited + 1;
    end
    if (reset) begin n_owner = -1; n_last = 1; n_waited = 0; end
  endtask

  task automatic adv();
    @(posedge clk);
    owner = n_owner; last = n_last; waited = n_waited;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1; eval(); adv(); reset = 1'b0;
  endtask

  initial begin
    int k, c0, c1, n, pulses;
    logic got;
    reset = 1'b1; s_ready = 1'b0; s_rdata = '0;
    for (int i = 0; i < 2; i++) begin mv[i] = 1'b0; ma[i] = '0; mw[i] = '0; ms[i] = '0; end
    @(negedge clk);
    repeat (2) begin eval(); adv(); end
    reset = 1'b0;
    eval();
    chk("rst_s_valid", 32'(s_valid), 0);
    chk("rst_m0_ready", 32'(m0_ready), 0);
    chk("rst_m1_ready", 32'(m1_ready), 0);
    adv();

    // Single read from requester 0
    mv[0] = 1'b1; ma[0] = 32'h100; ms[0] = 4'h0; mw[0] = 32'h0;
    eval(); chk("rd_sv_first", 32'(s_valid), 0); adv();
    eval(); chk("rd_sv_rise", 32'(s_valid), 1); chk("rd_addr", s_addr, 32'h100); adv();
    repeat (2) begin eval(); adv(); end
    s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
    eval();
    chk("rd_ready", 32'(m0_ready), 1);
    chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_err", 32'(m0_err), 0);
    chk("rd_m1_ready", 32'(m1_ready), 0);
    adv();
    mv[0] = 1'b0; s_ready = 1'b0;
    eval(); chk("rd_idle", 32'(s_valid), 0); adv();

    // Simultaneous first requests after reset
    pulse_reset();
    mv[0] = 1'b1; mv[1] = 1'b1; ma[0] = 32'h400; ma[1] = 32'h800;
    eval(); adv();
    s_ready = 1'b1;
    eval(); chk("tie_addr0", s_addr, 32'h400); chk("tie_m0_ready", 32'(m0_ready), 1); adv();
    mv[0] = 1'b0; s_ready = 1'b0;
    eval(); chk("tie_direct", 32'(s_valid), 1); chk("tie_addr1", s_addr, 32'h800); adv();
    s_ready = 1'b1;
    eval(); chk("tie_m1_ready", 32'(m1_ready), 1); adv();
    mv[1] = 1'b0; s_ready = 1'b0;
    eval(); adv();

    // Fairness with both requesters always asking
    pulse_reset();
    mv[0] = 1'b1; mv[1] = 1'b1;
    k = 0; c0 = 0; c1 = 0;
    for (int cyc = 0; cyc < 200 && k < 10; cyc++) begin
      s_ready = cyc[0];
      eval();
      if (m0_ready || m1_ready) begin
        chk("fair_order", 32'(m1_ready), 32'(k % 2));
        if (m0_ready) c0++; else c1++;
        k++;
      end
      adv();
    end
    chk("fair_total", k, 10);
    chk("fair_c0", c0, 5);
    chk("fair_c1", c1, 5);
    mv[0] = 1'b0; mv[1] = 1'b0; s_ready = 1'b0;
    repeat (2) begin eval(); adv(); end

    // Write passthrough from requester 1
    mv[1] = 1'b1; ma[1] = 32'h2000; mw[1] = 32'h12345678; ms[1] = 4'b0011;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      s_ready = (c == 3);
      eval();
      if (s_valid) begin
        chk("wr_addr", s_addr, 32'h2000);
        chk("wr_wdata", s_wdata, 32'h12345678);
        chk("wr_wstrb", 32'(s_wstrb), 32'h3);
      end
      got = m1_ready;
      if (got) pulses++;
      adv();
      if (got) mv[1] = 1'b0;
    end
    chk("wr_pulses", pulses, 1);
    s_ready = 1'b0;

    // Watchdog expiry with s_ready held low
    mv[0] = 1'b1; ma[0] = 32'h300; ms[0] = 4'h0;
    eval(); adv();
    n = 0; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      n++;
      eval();
      got = m0_ready;
      if (got) chk("wd_err", 32'(m0_err), 1);
      adv();
    end
    chk("wd_cycles", n, TO);
    mv[0] = 1'b0;
    eval(); chk("wd_idle", 32'(s_valid), 0); adv();

    // Completion arriving in the timeout cycle wins
    mv[0] = 1'b1;
    eval(); adv();
    for (int c = 1; c <= TO; c++) begin
      s_ready = (c == TO);
      eval();
      if (c == TO) begin
        chk("wd_late_ready", 32'(m0_ready), 1);
        chk("wd_late_err", 32'(m0_err), 0);
      end
      adv();
    end
    mv[0] = 1'b0; s_ready = 1'b0;
    eval(); adv();

    // Abort: requester drops valid mid-grant
    mv[0] = 1'b1;
    eval(); adv();
    repeat (2) begin eval(); adv(); end
    mv[0] = 1'b0;
    eval(); chk("ab_ready", 32'(m0_ready), 0); chk("ab_sv", 32'(s_valid), 1); adv();
    eval(); chk("ab_idle", 32'(s_valid), 0); adv();

    // Reset mid-grant, then a tie must go to requester 0
    mv[0] = 1'b1; ma[0] = 32'hA0; ma[1] = 32'hB0;
    eval(); adv();
    eval(); adv();
    pulse_reset();
    mv[1] = 1'b1;
    eval(); chk("rm_sv", 32'(s_valid), 0); adv();
    eval(); chk("rm_tie_sv", 32'(s_valid), 1); chk("rm_tie_addr", s_addr, 32'hA0); adv();
    mv[0] = 1'b0; mv[1] = 1'b0;
    repeat (2) begin eval(); adv(); end

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!mv[i] || e_rdy[i]) begin
          if ((!mv[i] && $urandom_range(3) == 0) || (mv[i] && $urandom_range(1) == 0)) begin
            mv[i] = 1'b1;
            ma[i] = $urandom;
            mw[i] = $urandom;
            ms[i] = 4'($urandom_range(15));
          end else begin
            mv[i] = 1'b0;
          end
        end else if ($urandom_range(39) == 0) begin
          mv[i] = 1'b0;
        end
      end
      s_ready = ($urandom_range(2) == 0);
      s_rdata = $urandom;
      reset   = ($urandom_range(199) == 0);
      eval();
      adv();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one native memory port (valid/ready, 32-bit data, byte strobes) between two requesters.
- Requester 0 is the kianV core's mem_valid/mem_ready interface; requester 1 is a DMA/debug master.
- Round-robin grant, held for the whole transaction, with a per-transaction watchdog that completes hung accesses with an error flag.
- Sits between the core plus DMA and the SoC memory/peripheral interconnect.

Parameters:
- ADDR_W, 32, address width for all ports.
- TIMEOUT, 1024, cycles a granted transaction may wait for s_ready before forced completion; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- m0_valid  in  1  requester 0 request; held until m0_ready.
- m0_ready  out  1  requester 0 completion pulse.
- m0_addr  in  ADDR_W  requester 0 address.
- m0_wdata  in  32  requester 0 write data.
- m0_wstrb  in  4  requester 0 byte strobes; 0 means read.
- m0_rdata  out  32  read data.
- m0_err  out  1  qualifies m0_ready: transaction timed out.
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_err: same as m0_* for requester 1.
- s_valid  out  1  downstream request.
- s_ready  in  1  downstream completion.
- s_addr  out  ADDR_W  downstream address.
- s_wdata  out  32  downstream write data.
- s_wstrb  out  4  downstream byte strobes.
- s_rdata  in  32  downstream read data.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values:
  - state IDLE, last_grant=1 (so requester 0 wins the first tie), watchdog count=0.
  - s_valid=0, m0_ready=m1_ready=0, m0_err=m1_err=0.
- State IDLE:
  - s_valid=0; no ready pulses.
  - Only one valid: go to that requester's grant state (GRANT0 or GRANT1).
  - Both valid: grant the requester that is not last_grant.
  - Arbitration is registered, so s_valid rises 1 cycle after the request is first seen in IDLE.
- States GRANT0 / GRANT1:
  - s_valid=1.
  - s_addr/s_wdata/s_wstrb are combinationally muxed from the granted requester.
  - On entry, last_grant is set to the granted index and count is cleared.
- Normal completion (s_ready=1 in a grant state):
  - Granted mX_ready=1 in the same cycle (combinational pass-through).
  - mX_err=0.
  - Next state: if the other requester's valid=1, go directly to its grant state (no IDLE bubble); otherwise IDLE.
- Read data:
  - m0_rdata = m1_rdata = s_rdata.
  - Valid only when the corresponding mX_ready=1.
- Ungranted requester: ready=0 and err=0 always.
- Watchdog (TIMEOUT>0):
  - count increments each grant cycle without s_ready.
  - When count==TIMEOUT-1 and s_ready=0: mX_ready=1 and mX_err=1 for exactly that cycle, s_valid remains 1 that cycle, rdata undefined.
  - Next state is chosen as for normal completion.
  - If s_ready=1 in the timeout cycle, normal completion wins and err=0.
- Watchdog width: count is $clog2(TIMEOUT+1) bits and never wraps.
- Abort: if the granted requester drops valid before completion (e.g. core reset), next state is IDLE. s_valid deasserts the following cycle, no ready pulse is generated, and the downstream access is abandoned.
- Requester holding valid after its own completion: treated as a new request and arbitrated normally. The other requester wins if both are valid.
- Reset mid-transaction: return to IDLE next edge, outputs as reset values; downstream is expected to be reset together.
- No combinational path from s_ready to s_valid.

Test Plan:
- Single read: m0_valid=1, addr=0x100, wstrb=0; s_ready raised 3 cycles after s_valid with s_rdata=0xDEADBEEF -> s_valid rises 1 cycle after m0_valid; m0_ready=1 with m0_rdata=0xDEADBEEF; m0_err=0; m1_ready stays 0.
- Simultaneous first requests: both valid from reset -> GRANT0 first; on its s_ready, direct GRANT1 with no IDLE cycle; s_addr switches to m1_addr.
- Fairness: both requesters continuously re-requesting over 10 completions -> grants alternate 0,1,0,1…, each completing 5 times.
- Write passthrough: m1 wstrb=0b0011, wdata=0x12345678, addr=0x2000 -> s_* outputs match exactly while granted; single m1_ready pulse.
- Watchdog: TIMEOUT=8, s_ready held 0 -> m0_ready=m0_err=1 on the 8th grant cycle; then IDLE. Variant with s_ready=1 on that same cycle -> m0_err=0.
- Abort and reset: m0_valid dropped 2 cycles into grant -> IDLE, no m0_ready. reset pulsed mid-grant -> s_valid=0 next cycle; next tie goes to requester 0.
